bakery_scheduler: RTL

- Sequential scheduler for the bakery mutual-exclusion case-study models.
- Each cycle it decides which process takes a step (select), when the whole system stutters (pause), and which symmetry class is active (sym_break).
- Replaces free environment choice with a fair, bounded-wait, round-robin schedule. Its outputs drive the select, pause and sym_break inputs of the bakery process model.

---
 rtl/bakery_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bakery_scheduler.sv
// Round-robin step scheduler for the bakery process model: picks one enabled
// process per cycle, inserts bounded pause runs and tracks the symmetry class.
module bakery_scheduler #(
  parameter int N         = 4,
  parameter int SEL_W     = 2,
  parameter int MAX_WAIT  = 7,
  parameter int MAX_PAUSE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             hold,
  input  logic             sym_en,
  output logic [SEL_W-1:0] select,
  output logic             grant_valid,
  output logic             pause,
  output logic [1:0]       sym_break,
  output logic             starve
);

  typedef enum logic {RUN, PAUSE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [3:0]       wcnt_q [N];
  logic [3:0]       wcnt_d [N];
  logic             gv_q, gv_d;
  logic             pause_q, pause_d;
  logic [1:0]       sym_q, sym_d;
  logic             starve_q, starve_d;

  logic             run;
  logic             grant;
  logic             force_hit;
  logic [SEL_W-1:0] force_idx;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] gnt_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      ptr_q    <= '0;
      sel_q    <= '0;
      pcnt_q   <= '0;
      gv_q     <= 1'b0;
      pause_q  <= 1'b0;
      sym_q    <= 2'b00;
      starve_q <= 1'b0;
      for (int i = 0; i < N; i++) wcnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      pcnt_q   <= pcnt_d;
      gv_q     <= gv_d;
      pause_q  <= pause_d;
      sym_q    <= sym_d;
      starve_q <= starve_d;
      for (int i = 0; i < N; i++) wcnt_q[i] <= wcnt_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gv_d      = 1'b0;
    pause_d   = 1'b1;
    starve_d  = 1'b0;
    run       = 1'b0;
    force_hit = 1'b0;
    force_idx = '0;
    rr_idx    = '0;

    case (state_q)
      RUN: begin
        if (hold) begin
          state_d = PAUSE;
          pcnt_d  = 4'd1;
        end else begin
          run = 1'b1;
        end
      end
      PAUSE: begin
        if (!hold) begin
          state_d = RUN;
          pcnt_d  = '0;
        end else if (pcnt_q < 4'(MAX_PAUSE)) begin
          pcnt_d = pcnt_q + 4'd1;
        end else begin
          // Pause budget spent: one run cycle is taken despite hold.
          state_d = RUN;
          pcnt_d  = '0;
          run     = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Descending scans so the lowest index / smallest ptr offset wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && wcnt_q[i] == 4'(MAX_WAIT)) begin
        force_hit = 1'b1;
        force_idx = SEL_W'(i);
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % N]) rr_idx = SEL_W'((int'(ptr_q) + k) % N);
    end

    grant   = run && (req != '0);
    gnt_idx = force_hit ? force_idx : rr_idx;

    if (grant) begin
      sel_d    = gnt_idx;
      gv_d     = 1'b1;
      pause_d  = 1'b0;
      starve_d = force_hit;
      ptr_d    = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end

    for (int i = 0; i < N; i++) begin
      if (!req[i] || (grant && int'(gnt_idx) == i)) wcnt_d[i] = '0;
      else if (wcnt_q[i] != 4'(MAX_WAIT))           wcnt_d[i] = wcnt_q[i] + 4'd1;
      else                                          wcnt_d[i] = wcnt_q[i];
    end

    // The class steps once per visible grant and collapses when sym_en drops.
    if (!sym_en)                      sym_d = 2'b00;
    else if (gv_q && sym_q != 2'b10)  sym_d = sym_q + 2'b01;
    else                              sym_d = sym_q;
  end

  assign select      = sel_q;
  assign grant_valid = gv_q;
  assign pause       = pause_q;
  assign sym_break   = sym_q;
  assign starve      = starve_q;

endmodule
